// File: rtl/dcache_controller_if.sv
// CPU request/response and memory-bus signals of the data cache controller.
// The cache uses the slave view; the CPU/memory environment uses the master view.
interface dcache_controller_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int CHUNKS_LOG = 4
);
    localparam int LINE_W = DATA_WIDTH << CHUNKS_LOG;

    // CPU side
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_store;
    logic [ADDR_WIDTH-1:0]   req_addr;
    logic [DATA_WIDTH-1:0]   req_wdata;
    logic [DATA_WIDTH/8-1:0] req_wstrb;
    logic                    resp_valid;
    logic [DATA_WIDTH-1:0]   resp_rdata;

    // Memory bus side
    logic                    cmd_valid;
    logic                    cmd_store;
    logic                    cmd_rready;
    logic [ADDR_WIDTH-1:0]   cmd_addr;
    logic [LINE_W-1:0]       cmd_data;
    logic                    bus_valid;
    logic                    bus_ready;
    logic [LINE_W-1:0]       bus_data;
    logic                    invalidate;
    logic [ADDR_WIDTH-1:0]   invalidate_addr;

    modport slave (
        input  req_valid, req_store, req_addr, req_wdata, req_wstrb,
        input  bus_valid, bus_ready, bus_data, invalidate, invalidate_addr,
        output req_ready, resp_valid, resp_rdata,
        output cmd_valid, cmd_store, cmd_rready, cmd_addr, cmd_data
    );

    modport master (
        output req_valid, req_store, req_addr, req_wdata, req_wstrb,
        output bus_valid, bus_ready, bus_data, invalidate, invalidate_addr,
        input  req_ready, resp_valid, resp_rdata,
        input  cmd_valid, cmd_store, cmd_rready, cmd_addr, cmd_data
    );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back / write-allocate data cache controller.
// One outstanding CPU request, whole-line bus transfers, and snoop
// invalidations honoured in every state (dirty data is dropped, not written back).
module dcache_controller #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64,
    parameter int CHUNKS_LOG = 4,
    parameter int SETS_LOG   = 4
) (
    input  logic               clk,
    input  logic               reset,
    dcache_controller_if.slave cif
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int BYTE_LOG = $clog2(STRB_W);
    localparam int OFFS_W   = BYTE_LOG + CHUNKS_LOG;
    localparam int TAG_LSB  = OFFS_W + SETS_LOG;
    localparam int TAG_W    = ADDR_WIDTH - TAG_LSB;
    localparam int SETS     = 1 << SETS_LOG;
    localparam int LINE_W   = DATA_WIDTH << CHUNKS_LOG;

    typedef enum logic [2:0] {
        IDLE, LOOKUP, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, RESPOND
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  store_q, store_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]     wstrb_q, wstrb_d;
    logic [ADDR_WIDTH-1:0] cmd_addr_q, cmd_addr_d;
    logic [LINE_W-1:0]     cmd_data_q, cmd_data_d;
    logic [SETS-1:0]       valid_q, valid_d;
    logic [SETS-1:0]       dirty_q, dirty_d;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [LINE_W-1:0]     data_q [SETS];

    logic [SETS_LOG-1:0]   req_idx, inv_idx;
    logic [TAG_W-1:0]      req_tag, inv_tag, inv_cur_tag;
    logic [CHUNKS_LOG-1:0] req_word;
    logic [LINE_W-1:0]     cur_line, line_wdata;
    logic [DATA_WIDTH-1:0] cur_word, resp_rdata;
    logic                  hit, line_we, tag_we, resp_valid, cmd_rready;
    logic                  unused_low_bits;

    assign req_idx  = addr_q[TAG_LSB-1:OFFS_W];
    assign req_tag  = addr_q[ADDR_WIDTH-1:TAG_LSB];
    assign req_word = addr_q[OFFS_W-1:BYTE_LOG];
    assign inv_idx  = cif.invalidate_addr[TAG_LSB-1:OFFS_W];
    assign inv_tag  = cif.invalidate_addr[ADDR_WIDTH-1:TAG_LSB];
    assign cur_line = data_q[req_idx];
    assign cur_word = cur_line[int'(req_word)*DATA_WIDTH +: DATA_WIDTH];
    assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Byte offsets are ignored: accesses are word-aligned, lines line-aligned.
    assign unused_low_bits = ^{addr_q[BYTE_LOG-1:0], cif.invalidate_addr[OFFS_W-1:0]};

    // Byte-enable merge of the store word into a copy of the line.
    function automatic logic [LINE_W-1:0] merge_line(
        input logic [LINE_W-1:0]     line,
        input logic [CHUNKS_LOG-1:0] word,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [STRB_W-1:0]     wstrb
    );
        logic [LINE_W-1:0] res;
        res = line;
        for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) res[int'(word)*DATA_WIDTH + b*8 +: 8] = wdata[b*8 +: 8];
        end
        return res;
    endfunction

    // Next-state, array write controls and CPU-side outputs.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        store_d     = store_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        line_we     = 1'b0;
        line_wdata  = cur_line;
        tag_we      = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = '0;
        cmd_rready  = 1'b0;
        inv_cur_tag = '0;

        case (state_q)
            IDLE: begin
                if (cif.req_valid) begin
                    addr_d  = cif.req_addr;
                    store_d = cif.req_store;
                    wdata_d = cif.req_wdata;
                    wstrb_d = cif.req_wstrb;
                    state_d = LOOKUP;
                end
            end
            LOOKUP, RESPOND: begin
                if (state_q == RESPOND || hit) begin
                    // A store after a fill whose line was snooped away is dropped.
                    resp_valid = 1'b1;
                    if (!store_q) begin
                        resp_rdata = cur_word;
                    end else if (hit) begin
                        line_we          = 1'b1;
                        line_wdata       = merge_line(cur_line, req_word, wdata_q, wstrb_q);
                        dirty_d[req_idx] = 1'b1;
                    end
                    state_d = IDLE;
                end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                    cmd_addr_d = {tag_q[req_idx], req_idx, {OFFS_W{1'b0}}};
                    cmd_data_d = cur_line;
                    state_d    = WB_REQ;
                end else begin
                    cmd_addr_d = {req_tag, req_idx, {OFFS_W{1'b0}}};
                    state_d    = FILL_REQ;
                end
            end
            WB_REQ: begin
                if (!cif.bus_ready) state_d = WB_WAIT;
            end
            WB_WAIT: begin
                if (cif.bus_ready) begin
                    cmd_addr_d = {req_tag, req_idx, {OFFS_W{1'b0}}};
                    state_d    = FILL_REQ;
                end
            end
            FILL_REQ: begin
                if (!cif.bus_ready) state_d = FILL_WAIT;
            end
            FILL_WAIT: begin
                if (cif.bus_valid) begin
                    cmd_rready       = 1'b1;
                    line_we          = 1'b1;
                    line_wdata       = cif.bus_data;
                    tag_we           = 1'b1;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    state_d          = RESPOND;
                end
            end
            default: state_d = IDLE;
        endcase

        // Snoop sees the line as it stands after this cycle's fill.
        inv_cur_tag = (tag_we && inv_idx == req_idx) ? req_tag : tag_q[inv_idx];
        if (cif.invalidate && valid_d[inv_idx] && inv_cur_tag == inv_tag) begin
            valid_d[inv_idx] = 1'b0;
            dirty_d[inv_idx] = 1'b0;
        end
    end

    // Control state, request latch and bus command registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            valid_q    <= '0;
            dirty_q    <= '0;
            cmd_addr_q <= '0;
            cmd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            dirty_q    <= dirty_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
        end
        addr_q  <= addr_d;
        store_q <= store_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
    end

    // Tag and data arrays; contents are meaningful only where valid is set.
    always_ff @(posedge clk) begin
        if (line_we) data_q[req_idx] <= line_wdata;
        if (tag_we)  tag_q[req_idx]  <= req_tag;
    end

    assign cif.req_ready  = (state_q == IDLE);
    assign cif.resp_valid = resp_valid && !reset;
    assign cif.resp_rdata = resp_rdata;
    assign cif.cmd_valid  = (state_q == WB_REQ) || (state_q == WB_WAIT && !cif.bus_ready) ||
                            (state_q == FILL_REQ) || (state_q == FILL_WAIT);
    assign cif.cmd_store  = (state_q == WB_REQ) || (state_q == WB_WAIT);
    assign cif.cmd_rready = cmd_rready && !reset;
    assign cif.cmd_addr   = cmd_addr_q;
    assign cif.cmd_data   = cmd_data_q;
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: cold miss, hit, store merge, dirty
// eviction, snoop invalidation (idle and during fill), back-to-back requests
// and reset in the middle of a fill.
module tb_dcache_controller;
    localparam int DW = 64;
    localparam int AW = 64;
    localparam int CL = 4;
    localparam int SL = 4;
    localparam int LW = DW << CL;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   vectors     = 0;
    int   miscompares = 0;

    dcache_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHUNKS_LOG(CL)) cif ();

    dcache_controller #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CHUNKS_LOG(CL), .SETS_LOG(SL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .cif   (cif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Line whose word k is {seed, k}.
    function automatic logic [LW-1:0] mk_line(input logic [31:0] seed);
        logic [LW-1:0] l;
        for (int k = 0; k < 16; k++) l[k*64 +: 64] = {seed, 32'(k)};
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in IDLE; returns one step into the cycle after acceptance.
    task automatic send_req(input logic st, input logic [63:0] a,
                            input logic [63:0] wd, input logic [7:0] ws);
        cif.req_valid = 1'b1;
        cif.req_store = st;
        cif.req_addr  = a;
        cif.req_wdata = wd;
        cif.req_wstrb = ws;
        tick();
        cif.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (cif.req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready: got %b want 1", cif.req_ready); end
        vectors++; if (cif.resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid: got %b want 0", cif.resp_valid); end
        vectors++; if (cif.resp_rdata !== 64'h0) begin miscompares++; $display("FAIL rst_resp_rdata: got %h want 0", cif.resp_rdata); end
        vectors++; if (cif.cmd_valid !== 1'b0 || cif.cmd_store !== 1'b0 || cif.cmd_rready !== 1'b0) begin
            miscompares++; $display("FAIL rst_cmd_ctrl: got v%b s%b r%b want 000", cif.cmd_valid, cif.cmd_store, cif.cmd_rready);
        end
        vectors++; if (cif.cmd_addr !== 64'h0 || cif.cmd_data !== '0) begin miscompares++; $display("FAIL rst_cmd_bus: got addr %h want 0 (data nonzero=%b)", cif.cmd_addr, |cif.cmd_data); end
    endtask

    task automatic test_cold_load();
        logic [LW-1:0] line;
        line = mk_line(32'hC0DE0000);
        line[64 +: 64] = 64'hAA;
        send_req(1'b0, 64'h1008, 64'h0, 8'h0);
        @(negedge clk);
        vectors++; if (cif.resp_valid !== 1'b0 || cif.cmd_valid !== 1'b0) begin miscompares++; $display("FAIL cold_lookup: got resp %b cmd %b want 0 0", cif.resp_valid, cif.cmd_valid); end
        tick(); cif.bus_ready = 1'b0;
        @(negedge clk);
        vectors++; if (cif.cmd_valid !== 1'b1 || cif.cmd_store !== 1'b0) begin miscompares++; $display("FAIL cold_fill_cmd: got v%b s%b want 1 0", cif.cmd_valid, cif.cmd_store); end
        vectors++; if (cif.cmd_addr !== 64'h1000) begin miscompares++; $display("FAIL cold_fill_addr: got %h want 1000", cif.cmd_addr); end
        tick(); cif.bus_valid = 1'b1; cif.bus_data = line;
        @(negedge clk);
        vectors++; if (cif.cmd_rready !== 1'b1) begin miscompares++; $display("FAIL cold_rready: got %b want 1", cif.cmd_rready); end
        tick(); cif.bus_valid = 1'b0; cif.bus_ready = 1'b1;
        @(negedge clk);
        vectors++; if (cif.cmd_rready !== 1'b0 || cif.cmd_valid !== 1'b0) begin miscompares++; $display("FAIL cold_rready_pulse: got r%b v%b want 0 0", cif.cmd_rready, cif.cmd_valid); end
        vectors++; if (cif.resp_valid !== 1'b1 || cif.resp_rdata !== 64'hAA) begin miscompares++; $display("FAIL cold_resp: got %b %h want 1 aa", cif.resp_valid, cif.resp_rdata); end
        tick();
        @(negedge clk);
        vectors++; if (cif.resp_valid !== 1'b0 || cif.req_ready !== 1'b1) begin miscompares++; $display("FAIL cold_after: got resp %b ready %b want 0 1", cif.resp_valid, cif.req_ready); end
    endtask

    task automatic test_hit();
        send_req(1'b0, 64'h1008, 64'h0, 8'h0);
        @(negedge clk);
        vectors++; if (cif.resp_valid !== 1'b1 || cif.resp_rdata !== 64'hAA) begin miscompares++; $display("FAIL hit_resp: got %b %h want 1 aa", cif.resp_valid, cif.resp_rdata); end
        vectors++; if (cif.cmd_valid !== 1'b0) begin miscompares++; $display("FAIL hit_no_cmd: got %b want 0", cif.cmd_valid); end
        tick();
        @(negedge clk);
        vectors++; if (cif.resp_valid !== 1'b0 || cif.req_ready !== 1'b1) begin miscompares++; $display("FAIL hit_pulse: got resp %b ready %b want 0 1", cif.resp_valid, cif.req_ready); end
    endtask

    task automatic test_store_hit();
        send_req(1'b1, 64'h1010, 64'h11223344, 8'h0F);
        @(negedge clk);
        vectors++; if (cif.resp_valid !== 1'b1 || cif.resp_rdata !== 64'h0) begin miscompares++; $display("FAIL store_resp: got %b %h want 1 0", cif.resp_valid, cif.resp_rdata); end
        tick();
        @(negedge clk);
        send_req(1'b0, 64'h1010, 64'h0, 8'h0);
        @(negedge clk);
        vectors++; if (cif.resp_valid !== 1'b1 || cif.resp_rdata !== 64'hC0DE0000_11223344) begin miscompares++; $display("FAIL store_merge: got %b %h want 1 c0de000011223344", cif.resp_valid, cif.resp_rdata); end
        tick();
        @(negedge clk);
    endtask

    task automatic test_writeback();
        send_req(1'b0, 64'h1810, 64'h0, 8'h0);
        @(negedge clk);
        vectors++; if (cif.resp_valid !== 1'b0) begin miscompares++; $display("FAIL wb_lookup: got resp %b want 0", cif.resp_valid); end
        tick(); cif.bus_ready = 1'b0;
        @(negedge clk);
        vectors++; if (cif.cmd_valid !== 1'b1 || cif.cmd_store !== 1'b1 || cif.cmd_addr !== 64'h1000) begin miscompares++; $display("FAIL wb_cmd: got v%b s%b %h want 1 1 1000", cif.cmd_valid, cif.cmd_store, cif.cmd_addr); end
        vectors++; if (cif.cmd_data[128 +: 64] !== 64'hC0DE0000_11223344 || cif.cmd_data[64 +: 64] !== 64'hAA) begin miscompares++; $display("FAIL wb_data: got w2 %h w1 %h want c0de000011223344 aa", cif.cmd_data[128 +: 64], cif.cmd_data[64 +: 64]); end
        tick();
        @(negedge clk);
        vectors++; if (cif.cmd_valid !== 1'b1 || cif.cmd_addr !== 64'h1000) begin miscompares++; $display("FAIL wb_wait_hold: got v%b %h want 1 1000", cif.cmd_valid, cif.cmd_addr); end
        tick(); cif.bus_ready = 1'b1;
        @(negedge clk);
        vectors++; if (cif.cmd_valid !== 1'b0) begin miscompares++; $display("FAIL wb_drop: got %b want 0", cif.cmd_valid); end
        tick(); cif.bus_ready = 1'b0;
        @(negedge clk);
        vectors++; if (cif.cmd_valid !== 1'b1 || cif.cmd_store !== 1'b0 || cif.cmd_addr !== 64'h1800) begin miscompares++; $display("FAIL wb_fill_cmd: got v%b s%b %h want 1 0 1800", cif.cmd_valid, cif.cmd_store, cif.cmd_addr); end
        tick(); cif.bus_valid = 1'b1; cif.bus_data = mk_line(32'hBEEF0000);
        @(negedge clk);
        vectors++; if (cif.cmd_rready !== 1'b1) begin miscompares++; $display("FAIL wb_fill_rready: got %b want 1", cif.cmd_rready); end
        tick(); cif.bus_valid = 1'b0; cif.bus_ready = 1'b1;
        @(negedge clk);
        vectors++; if (cif.resp_valid !== 1'b1 || cif.resp_rdata !== 64'hBEEF0000_00000002) begin miscompares++; $display("FAIL wb_resp: got %b %h want 1 beef000000000002", cif.resp_valid, cif.resp_rdata); end
        tick();
        @(negedge clk);
    endtask

    task automatic test_invalidate();
        // Make the resident line dirty, then snoop a non-matching tag in the same set.
        send_req(1'b1, 64'h1800, 64'h0123456789ABCDEF, 8'hFF);
        tick();
        @(negedge clk);
        cif.invalidate = 1'b1; cif.invalidate_addr = 64'h2000;
        tick(); cif.invalidate = 1'b0;
        @(negedge clk);
        send_req(1'b0, 64'h1800, 64'h0, 8'h0);
        @(negedge clk);
        vectors++; if (cif.resp_valid !== 1'b1 || cif.resp_rdata !== 64'h0123456789ABCDEF) begin miscompares++; $display("FAIL inv_other_tag: got %b %h want 1 0123456789abcdef", cif.resp_valid, cif.resp_rdata); end
        tick();
        @(negedge clk);
        cif.invalidate = 1'b1; cif.invalidate_addr = 64'h1800;
        tick(); cif.invalidate = 1'b0;
        @(negedge clk);
        send_req(1'b0, 64'h1800, 64'h0, 8'h0);
        @(negedge clk);
        vectors++; if (cif.resp_valid !== 1'b0) begin miscompares++; $display("FAIL inv_miss: got resp %b want 0", cif.resp_valid); end
        tick(); cif.bus_ready = 1'b0;
        @(negedge clk);
        vectors++; if (cif.cmd_valid !== 1'b1 || cif.cmd_store !== 1'b0 || cif.cmd_addr !== 64'h1800) begin miscompares++; $display("FAIL inv_refill_cmd: got v%b s%b %h want 1 0 1800", cif.cmd_valid, cif.cmd_store, cif.cmd_addr); end
        tick(); cif.bus_valid = 1'b1; cif.bus_data = mk_line(32'h5EED0000);
        tick(); cif.bus_valid = 1'b0; cif.bus_ready = 1'b1;
        @(negedge clk);
        vectors++; if (cif.resp_valid !== 1'b1 || cif.resp_rdata !== 64'h5EED0000_00000000) begin miscompares++; $display("FAIL inv_refill_resp: got %b %h want 1 5eed000000000000", cif.resp_valid, cif.resp_rdata); end
        tick();
        @(negedge clk);
    endtask

    task automatic test_inv_during_fill();
        send_req(1'b0, 64'h2088, 64'h0, 8'h0);
        tick(); cif.bus_ready = 1'b0;
        @(negedge clk);
        vectors++; if (cif.cmd_addr !== 64'h2080) begin miscompares++; $display("FAIL ifill_addr: got %h want 2080", cif.cmd_addr); end
        tick();
        cif.bus_valid = 1'b1; cif.bus_data = mk_line(32'h1DEA0000);
        cif.invalidate = 1'b1; cif.invalidate_addr = 64'h2080;
        tick(); cif.bus_valid = 1'b0; cif.bus_ready = 1'b1; cif.invalidate = 1'b0;
        @(negedge clk);
        vectors++; if (cif.resp_valid !== 1'b1 || cif.resp_rdata !== 64'h1DEA0000_00000001) begin miscompares++; $display("FAIL ifill_resp: got %b %h want 1 1dea000000000001", cif.resp_valid, cif.resp_rdata); end
        tick();
        @(negedge clk);
        send_req(1'b0, 64'h2088, 64'h0, 8'h0);
        @(negedge clk);
        vectors++; if (cif.resp_valid !== 1'b0) begin miscompares++; $display("FAIL ifill_line_gone: got resp %b want 0", cif.resp_valid); end
        tick(); cif.bus_ready = 1'b0;
        @(negedge clk);
        vectors++; if (cif.cmd_valid !== 1'b1 || cif.cmd_store !== 1'b0) begin miscompares++; $display("FAIL ifill_refill_cmd: got v%b s%b want 1 0", cif.cmd_valid, cif.cmd_store); end
        tick(); cif.bus_valid = 1'b1; cif.bus_data = mk_line(32'h2DEA0000);
        tick(); cif.bus_valid = 1'b0; cif.bus_ready = 1'b1;
        @(negedge clk);
        vectors++; if (cif.resp_rdata !== 64'h2DEA0000_00000001) begin miscompares++; $display("FAIL ifill_refill_data: got %h want 2dea000000000001", cif.resp_rdata); end
        tick();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        cif.req_valid = 1'b1; cif.req_store = 1'b0; cif.req_addr = 64'h1808;
        tick();
        @(negedge clk);
        vectors++; if (cif.resp_valid !== 1'b1 || cif.resp_rdata !== 64'h5EED0000_00000001 || cif.req_ready !== 1'b0) begin
            miscompares++; $display("FAIL b2b_first: got %b %h ready %b want 1 5eed000000000001 0", cif.resp_valid, cif.resp_rdata, cif.req_ready);
        end
        tick();
        @(negedge clk);
        vectors++; if (cif.resp_valid !== 1'b0 || cif.req_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_gap: got resp %b ready %b want 0 1", cif.resp_valid, cif.req_ready); end
        tick();
        @(negedge clk);
        vectors++; if (cif.resp_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_second: got %b want 1", cif.resp_valid); end
        cif.req_valid = 1'b0;
        tick();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_fill();
        send_req(1'b0, 64'h3100, 64'h0, 8'h0);
        tick(); cif.bus_ready = 1'b0;
        tick();
        @(negedge clk);
        vectors++; if (cif.cmd_valid !== 1'b1 || cif.cmd_addr !== 64'h3100) begin miscompares++; $display("FAIL rmf_fill_wait: got v%b %h want 1 3100", cif.cmd_valid, cif.cmd_addr); end
        reset = 1'b1;
        tick(); reset = 1'b0;
        @(negedge clk);
        vectors++; if (cif.cmd_valid !== 1'b0 || cif.req_ready !== 1'b1 || cif.cmd_addr !== 64'h0) begin
            miscompares++; $display("FAIL rmf_after_reset: got v%b ready %b %h want 0 1 0", cif.cmd_valid, cif.req_ready, cif.cmd_addr);
        end
        cif.bus_valid = 1'b1; cif.bus_data = mk_line(32'hDEAD0000);
        tick();
        @(negedge clk);
        vectors++; if (cif.cmd_rready !== 1'b0 || cif.resp_valid !== 1'b0) begin miscompares++; $display("FAIL rmf_bus_ignored: got r%b resp %b want 0 0", cif.cmd_rready, cif.resp_valid); end
        cif.bus_valid = 1'b0; cif.bus_ready = 1'b1;
        send_req(1'b0, 64'h1800, 64'h0, 8'h0);
        @(negedge clk);
        vectors++; if (cif.resp_valid !== 1'b0) begin miscompares++; $display("FAIL rmf_valid_cleared: got resp %b want 0", cif.resp_valid); end
        tick();
        @(negedge clk);
        vectors++; if (cif.cmd_valid !== 1'b1 || cif.cmd_store !== 1'b0 || cif.cmd_addr !== 64'h1800) begin miscompares++; $display("FAIL rmf_refetch: got v%b s%b %h want 1 0 1800", cif.cmd_valid, cif.cmd_store, cif.cmd_addr); end
    endtask

    initial begin
        cif.req_valid       = 1'b0;
        cif.req_store       = 1'b0;
        cif.req_addr        = '0;
        cif.req_wdata       = '0;
        cif.req_wstrb       = '0;
        cif.bus_valid       = 1'b0;
        cif.bus_ready       = 1'b1;
        cif.bus_data        = '0;
        cif.invalidate      = 1'b0;
        cif.invalidate_addr = '0;

        test_reset();
        test_cold_load();
        test_hit();
        test_store_hit();
        test_writeback();
        test_invalidate();
        test_inv_during_fill();
        test_back_to_back();
        test_reset_mid_fill();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
